// File: rtl/cic_dec_ctrl.sv
// Sequencing controller for a 5-stage, D=2 CIC decimator with a run-time programmable rate.
// Flushes the filter on start-up and on rate changes, then drops its settling outputs.
module cic_dec_ctrl #(
    parameter int unsigned INPUT_WIDTH    = 15,
    parameter int unsigned OUTPUT_WIDTH   = 38,
    parameter int unsigned RATE_WIDTH     = 4,
    parameter int unsigned DEFAULT_RATE   = 12,
    parameter int unsigned FLUSH_CYCLES   = 2,
    parameter int unsigned SETTLE_OUTPUTS = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    cfg_wr_i,
    input  logic [RATE_WIDTH-1:0]   cfg_rate_i,
    output logic                    cfg_err_o,
    output logic                    busy_o,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [INPUT_WIDTH-1:0]  s_data_i,
    output logic                    cic_rst_o,
    output logic                    cic_nd_o,
    output logic [INPUT_WIDTH-1:0]  cic_din_o,
    output logic [RATE_WIDTH-1:0]   cic_rate_o,
    input  logic                    cic_rdy_i,
    input  logic [OUTPUT_WIDTH-1:0] cic_dout_i,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [OUTPUT_WIDTH-1:0] m_data_o,
    output logic                    ovf_o
);
    localparam int unsigned FlushW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned DiscW  = (SETTLE_OUTPUTS > 0) ? $clog2(SETTLE_OUTPUTS + 1) : 1;

    localparam logic [FlushW-1:0]     FlushLast = FlushW'(FLUSH_CYCLES - 1);
    localparam logic [DiscW-1:0]      DiscInit  = DiscW'(SETTLE_OUTPUTS);
    localparam logic [RATE_WIDTH-1:0] RateRst   = RATE_WIDTH'(DEFAULT_RATE);
    localparam logic [RATE_WIDTH-1:0] RateMin   = RATE_WIDTH'(2);

    typedef enum logic [1:0] {StIdle, StFlush, StSettle, StRun} state_e;

    state_e                  state_q, state_d;
    logic [FlushW-1:0]       flush_cnt_q, flush_cnt_d;
    logic [DiscW-1:0]        disc_cnt_q, disc_cnt_d;
    logic [RATE_WIDTH-1:0]   rate_q, rate_d;
    logic                    cic_nd_q, cic_nd_d;
    logic [INPUT_WIDTH-1:0]  cic_din_q, cic_din_d;
    logic                    m_valid_q, m_valid_d;
    logic [OUTPUT_WIDTH-1:0] m_data_q, m_data_d;
    logic                    ovf_q, ovf_d;
    logic                    cfg_err_q, cfg_err_d;

    logic cfg_legal, cfg_acc, hs, load;

    assign cfg_legal = cfg_rate_i >= RateMin;
    assign cfg_acc   = cfg_wr_i && cfg_legal;
    assign hs        = s_valid_i && s_ready_o;
    // A rate change or disable in the same cycle discards the decimator output.
    assign load      = (state_q == StRun) && cic_rdy_i && enable_i && !cfg_acc;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        disc_cnt_d  = disc_cnt_q;
        rate_d      = rate_q;
        if (cfg_acc) begin
            rate_d = cfg_rate_i;
        end
        unique case (state_q)
            StIdle: begin
                if (enable_i) begin
                    state_d     = StFlush;
                    flush_cnt_d = '0;
                end
            end
            StFlush: begin
                if (flush_cnt_q == FlushLast) begin
                    state_d    = (DiscInit == '0) ? StRun : StSettle;
                    disc_cnt_d = DiscInit;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            StSettle: begin
                if (cic_rdy_i) begin
                    disc_cnt_d = disc_cnt_q - 1'b1;
                    if (disc_cnt_q == DiscW'(1)) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: state_d = StIdle;
        endcase
        if (cfg_acc) begin
            state_d     = StFlush;
            flush_cnt_d = '0;
        end
        if (!enable_i) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        cic_nd_d  = hs;
        cic_din_d = hs ? s_data_i : cic_din_q;
        cfg_err_d = cfg_wr_i && !cfg_legal;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        ovf_d     = ovf_q;
        if (m_valid_q && m_ready_i) begin
            m_valid_d = 1'b0;
        end
        if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = cic_dout_i;
            if (m_valid_q && !m_ready_i) begin
                ovf_d = 1'b1;
            end
        end
        if (cfg_acc) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            flush_cnt_q <= '0;
            disc_cnt_q  <= '0;
            rate_q      <= RateRst;
            cic_nd_q    <= 1'b0;
            cic_din_q   <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            ovf_q       <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            disc_cnt_q  <= disc_cnt_d;
            rate_q      <= rate_d;
            cic_nd_q    <= cic_nd_d;
            cic_din_q   <= cic_din_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            ovf_q       <= ovf_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Handshake-facing outputs decode the registered state only.
    assign cic_rst_o  = (state_q == StIdle) || (state_q == StFlush);
    assign busy_o     = (state_q == StFlush) || (state_q == StSettle);
    assign s_ready_o  = (state_q == StSettle) || (state_q == StRun);
    assign cic_nd_o   = cic_nd_q;
    assign cic_din_o  = cic_din_q;
    assign cic_rate_o = rate_q;
    assign m_valid_o  = m_valid_q;
    assign m_data_o   = m_data_q;
    assign ovf_o      = ovf_q;
    assign cfg_err_o  = cfg_err_q;

endmodule
